// File: rtl/uart_rx_block_loader.sv
// uart_rx_block_loader: 8N1 UART receiver that packs NBYTES received bytes
// into one wide block (first byte in bits [7:0]) behind a valid/ready handshake.
// Partial blocks are dropped on a framing error or after an idle timeout.
module uart_rx_block_loader #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int NBYTES       = 40,
  parameter int TIMEOUT_CLKS = 125000
) (
  input  logic                         hwclk,
  input  logic                         rst_n,
  input  logic                         rx,
  output logic                         byte_valid,
  output logic [7:0]                   byte_data,
  output logic                         frame_err,
  output logic                         overrun,
  output logic [$clog2(NBYTES+1)-1:0]  byte_count,
  output logic                         block_valid,
  input  logic                         block_ready,
  output logic [8*NBYTES-1:0]          block_data
);

  localparam int BCW = $clog2(NBYTES + 1);
  localparam int CW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TW  = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

  localparam logic [CW-1:0]  HALF_M1    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] LAST_IDX   = BCW'(NBYTES - 1);
  localparam logic [TW-1:0]  TIMEOUT_TC = TW'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                rxs_q, rxs_d;
  logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [TW-1:0]       idle_q, idle_d;
  logic                byte_valid_q, byte_valid_d;
  logic [7:0]          byte_data_q, byte_data_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic [BCW-1:0]      byte_count_q, byte_count_d;
  logic                block_valid_q, block_valid_d;
  logic [8*NBYTES-1:0] block_data_q, block_data_d;

  // Next-state logic: bit-level receive FSM, then block assembly, handshake and timeout.
  always_comb begin
    logic good_byte;
    good_byte     = 1'b0;
    state_d       = state_q;
    sync1_d       = rx;
    rxs_d         = sync1_q;
    clk_cnt_d     = clk_cnt_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    idle_d        = idle_q;
    byte_valid_d  = 1'b0;
    byte_data_d   = byte_data_q;
    frame_err_d   = 1'b0;
    overrun_d     = 1'b0;
    byte_count_d  = byte_count_q;
    block_valid_d = block_valid_q;
    block_data_d  = block_data_q;

    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
        end
      end
      S_START: begin
        // Re-check the line mid start bit so short low glitches are rejected.
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rxs_q) begin
            good_byte = 1'b1;
            state_d   = S_IDLE;
          end else begin
            // A completed block awaiting hand-off is not partial, so it survives.
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
            if (!block_valid_q) byte_count_d = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Consumer handshake releases the block for refilling.
    if (block_valid_q && block_ready) begin
      block_valid_d = 1'b0;
      byte_count_d  = '0;
    end

    // Idle timer only runs while a partial block is being built.
    if (TIMEOUT_CLKS > 0) begin
      if (good_byte || byte_count_q == '0) begin
        idle_d = '0;
      end else if (idle_q != TIMEOUT_TC) begin
        idle_d = idle_q + TW'(1);
      end
      if (!good_byte && !block_valid_q && byte_count_q != '0 && idle_q == TIMEOUT_TC) begin
        byte_count_d = '0;
        idle_d       = '0;
      end
    end

    if (good_byte) begin
      byte_valid_d = 1'b1;
      byte_data_d  = shift_q;
      if (block_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        block_data_d[8*int'(byte_count_q) +: 8] = shift_q;
        byte_count_d = byte_count_q + BCW'(1);
        if (byte_count_q == LAST_IDX) block_valid_d = 1'b1;
      end
    end
  end

  // State and output registers; reset parks the line synchroniser at idle-high.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b1;
      rxs_q         <= 1'b1;
      clk_cnt_q     <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      idle_q        <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= '0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      byte_count_q  <= '0;
      block_valid_q <= 1'b0;
      block_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      rxs_q         <= rxs_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      idle_q        <= idle_d;
      byte_valid_q  <= byte_valid_d;
      byte_data_q   <= byte_data_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      byte_count_q  <= byte_count_d;
      block_valid_q <= block_valid_d;
      block_data_q  <= block_data_d;
    end
  end

  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign byte_count  = byte_count_q;
  assign block_valid = block_valid_q;
  assign block_data  = block_data_q;

endmodule

// File: tb/tb_uart_rx_block_loader.sv
// Bench for uart_rx_block_loader: table of framed bytes plus hand-written
// sequences for glitch, overrun, timeout and mid-frame reset.
module tb_uart_rx_block_loader;

  localparam int CPB = 16;
  localparam int NB  = 4;
  localparam int TO  = 400;
  localparam int BCW = $clog2(NB + 1);

  logic            hwclk = 1'b0;
  logic            rst_n = 1'b0;
  logic            rx = 1'b1;
  logic            block_ready = 1'b0;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            frame_err;
  logic            overrun;
  logic [BCW-1:0]  byte_count;
  logic            block_valid;
  logic [8*NB-1:0] block_data;

  int tests = 0;
  int fails = 0;
  int n_bv = 0, n_fe = 0, n_ov = 0, n_blk = 0;

  logic [7:0]      exp_bytes[$];
  logic [8*NB-1:0] exp_blocks[$];

  typedef struct {
    logic [7:0]      data;
    logic            stop_ok;
    int              exp_count;
    logic            done_block;
    logic [8*NB-1:0] blk;
  } vec_t;

  vec_t vecs[10];

  always #5 hwclk = ~hwclk;

  uart_rx_block_loader #(
    .CLKS_PER_BIT(CPB),
    .NBYTES(NB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .hwclk(hwclk),
    .rst_n(rst_n),
    .rx(rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err),
    .overrun(overrun),
    .byte_count(byte_count),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .block_data(block_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n clocks and land 2 time units after the active edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge hwclk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cyc(CPB);
    end
    rx = stop;
    cyc(CPB);
    rx = 1'b1;
    cyc(CPB);
  endtask

  // Scoreboard monitor: pops expected bytes/blocks as the DUT produces them.
  always @(negedge hwclk) begin
    if (rst_n) begin
      if (byte_valid) begin
        n_bv++;
        if (exp_bytes.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_byte: got %0h expected none", byte_data);
        end else begin
          check("byte_data", {56'd0, byte_data}, {56'd0, exp_bytes.pop_front()});
        end
      end
      if (frame_err) n_fe++;
      if (overrun)   n_ov++;
      if (block_valid) begin
        n_blk++;
        if (block_ready) begin
          if (exp_blocks.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got %0h expected none", block_data);
          end else begin
            check("block_data", {32'd0, block_data}, {32'd0, exp_blocks.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    int bv0, fe0, blk0, ov0;

    vecs[0] = '{8'h01, 1'b1, 1, 1'b0, 32'h0};
    vecs[1] = '{8'h02, 1'b1, 2, 1'b0, 32'h0};
    vecs[2] = '{8'h03, 1'b1, 3, 1'b0, 32'h0};
    vecs[3] = '{8'h04, 1'b1, 0, 1'b1, 32'h04030201};
    vecs[4] = '{8'hA5, 1'b1, 1, 1'b0, 32'h0};
    vecs[5] = '{8'h5A, 1'b0, 0, 1'b0, 32'h0};
    vecs[6] = '{8'h3C, 1'b1, 1, 1'b0, 32'h0};
    vecs[7] = '{8'hC3, 1'b1, 2, 1'b0, 32'h0};
    vecs[8] = '{8'h00, 1'b1, 3, 1'b0, 32'h0};
    vecs[9] = '{8'hFF, 1'b1, 0, 1'b1, 32'hFF00C33C};

    // Reset state
    cyc(3);
    check("rst_byte_valid",  {63'd0, byte_valid}, 64'd0);
    check("rst_block_valid", {63'd0, block_valid}, 64'd0);
    check("rst_byte_count",  {60'd0, byte_count}, 64'd0);
    check("rst_block_data",  {32'd0, block_data}, 64'd0);
    rst_n = 1'b1;
    cyc(2 * CPB);
    check("idle_frame_err",  {63'd0, frame_err}, 64'd0);

    // Table-driven frames with block_ready held high
    block_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      bv0 = n_bv;
      fe0 = n_fe;
      blk0 = n_blk;
      if (vecs[v].stop_ok) exp_bytes.push_back(vecs[v].data);
      if (vecs[v].done_block) exp_blocks.push_back(vecs[v].blk);
      send_byte(vecs[v].data, vecs[v].stop_ok);
      check($sformatf("vec%0d_count", v), {60'd0, byte_count}, 64'(vecs[v].exp_count));
      check($sformatf("vec%0d_nbyte", v), 64'(n_bv - bv0), {63'd0, vecs[v].stop_ok});
      check($sformatf("vec%0d_nferr", v), 64'(n_fe - fe0), {63'd0, !vecs[v].stop_ok});
      check($sformatf("vec%0d_blkcyc", v), 64'(n_blk - blk0), {63'd0, vecs[v].done_block});
      if (vecs[v].stop_ok) check($sformatf("vec%0d_bdata", v), {56'd0, byte_data}, {56'd0, vecs[v].data});
    end

    // Short low glitch is rejected
    bv0 = n_bv;
    fe0 = n_fe;
    rx = 1'b0;
    cyc(5);
    rx = 1'b1;
    cyc(2 * CPB);
    check("glitch_nbyte", 64'(n_bv - bv0), 64'd0);
    check("glitch_nferr", 64'(n_fe - fe0), 64'd0);

    // Overrun while the block waits for the consumer
    block_ready = 1'b0;
    exp_bytes.push_back(8'h11); send_byte(8'h11, 1'b1);
    exp_bytes.push_back(8'h22); send_byte(8'h22, 1'b1);
    exp_bytes.push_back(8'h33); send_byte(8'h33, 1'b1);
    exp_bytes.push_back(8'h44); send_byte(8'h44, 1'b1);
    check("ovr_block_valid", {63'd0, block_valid}, 64'd1);
    check("ovr_count_full",  {60'd0, byte_count}, 64'd4);
    ov0 = n_ov;
    bv0 = n_bv;
    exp_bytes.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    check("ovr_pulse",       64'(n_ov - ov0), 64'd1);
    check("ovr_byte_pulse",  64'(n_bv - bv0), 64'd1);
    check("ovr_block_hold",  {32'd0, block_data}, 64'h44332211);
    cyc(TO + 50);
    check("ovr_still_valid", {63'd0, block_valid}, 64'd1);
    exp_blocks.push_back(32'h44332211);
    block_ready = 1'b1;
    cyc(3);
    check("ovr_accepted",    {63'd0, block_valid}, 64'd0);
    check("ovr_count_clr",   {60'd0, byte_count}, 64'd0);

    // Idle timeout discards a partial block
    exp_bytes.push_back(8'h55); send_byte(8'h55, 1'b1);
    exp_bytes.push_back(8'h66); send_byte(8'h66, 1'b1);
    check("to_partial",      {60'd0, byte_count}, 64'd2);
    cyc(500);
    check("to_cleared",      {60'd0, byte_count}, 64'd0);
    blk0 = n_blk;
    exp_blocks.push_back(32'hAA998877);
    exp_bytes.push_back(8'h77); send_byte(8'h77, 1'b1);
    exp_bytes.push_back(8'h88); send_byte(8'h88, 1'b1);
    exp_bytes.push_back(8'h99); send_byte(8'h99, 1'b1);
    exp_bytes.push_back(8'hAA); send_byte(8'hAA, 1'b1);
    check("to_block_once",   64'(n_blk - blk0), 64'd1);
    check("to_block_data",   {32'd0, block_data}, 64'hAA998877);

    // Reset in the middle of a data bit
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b1;
    cyc(CPB / 2);
    rst_n = 1'b0;
    cyc(3);
    check("mrst_block_data", {32'd0, block_data}, 64'd0);
    check("mrst_byte_data",  {56'd0, byte_data}, 64'd0);
    check("mrst_byte_count", {60'd0, byte_count}, 64'd0);
    check("mrst_flags",      {61'd0, byte_valid, frame_err, overrun}, 64'd0);
    rx = 1'b1;
    rst_n = 1'b1;
    cyc(2 * CPB);
    check("mrst_no_byte",    {63'd0, byte_valid}, 64'd0);
    exp_bytes.push_back(8'h81);
    send_byte(8'h81, 1'b1);
    check("mrst_rx_count",   {60'd0, byte_count}, 64'd1);
    check("mrst_rx_data",    {56'd0, byte_data}, 64'h81);

    // Everything expected was consumed
    cyc(4);
    check("sb_bytes_left",   64'(exp_bytes.size()), 64'd0);
    check("sb_blocks_left",  64'(exp_blocks.size()), 64'd0);
    check("total_frame_err", 64'(n_fe), 64'd1);
    check("total_overrun",   64'(n_ov), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
